// File: rtl/responder_arbiter.sv
// Quiz responder round controller: per-key debounce, foul lockout, first-press grant
// and countdown-timer sequencing (Start / Timer_Start / Answer).
// state | meaning: IDLE early presses are fouls | OPEN buzz window | ANSWER winner answering | DONE host stopped | EXPIRED timed out
module responder_arbiter #(
  parameter int N_PLAYERS       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int ID_W  = $clog2(N_PLAYERS),
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [N_PLAYERS-1:0] Key,
  input  logic                 Host_Go,
  input  logic                 Host_Stop,
  input  logic                 Host_Reset,
  input  logic                 TimeOver_Stop,
  output logic                 Start,
  output logic                 Timer_Start,
  output logic                 Answer,
  output logic                 Winner_Valid,
  output logic [ID_W-1:0]      Winner_ID,
  output logic [N_PLAYERS-1:0] Player_LED,
  output logic                 Foul,
  output logic [ID_W-1:0]      Foul_ID,
  output logic [N_PLAYERS-1:0] Lockout,
  output logic                 Round_Expired
);

  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_ANSWER, S_DONE, S_EXPIRED} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t state_q, state_d;

  logic [N_PLAYERS-1:0] sync1, sync2, deb, deb_q, press;
  logic [CNT_W-1:0]     cnt [N_PLAYERS];

  logic                 start_d, ts_d, ans_d, wv_d, foul_d, exp_d;
  logic [ID_W-1:0]      wid_d, fid_d, first;
  logic [N_PLAYERS-1:0] led_d, lock_d, valid;
  logic                 any;

  // Down-counter reloads whenever the synchronized key agrees with the debounced level
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      press <= '0;
      for (int i = 0; i < N_PLAYERS; i++) cnt[i] <= CNT_LOAD;
    end else begin
      sync1 <= Key;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= CNT_LOAD;
        end else if (cnt[i] == '0) begin
          deb[i] <= sync2[i];
          cnt[i] <= CNT_LOAD;
        end else begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    valid = press & ~Lockout;
    first = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (valid[i]) first = ID_W'(i);
    end
  end

  assign any = |valid;

  always_comb begin
    state_d = state_q;
    start_d = Start;
    ts_d    = Timer_Start;
    ans_d   = Answer;
    wv_d    = Winner_Valid;
    wid_d   = Winner_ID;
    led_d   = Player_LED;
    foul_d  = Foul;
    fid_d   = Foul_ID;
    lock_d  = Lockout;
    exp_d   = Round_Expired;
    if (Host_Reset) begin
      state_d = S_IDLE;
      start_d = 1'b1;
      ts_d    = 1'b0;
      ans_d   = 1'b0;
      wv_d    = 1'b0;
      wid_d   = '0;
      led_d   = '0;
      foul_d  = 1'b0;
      fid_d   = '0;
      lock_d  = '0;
      exp_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any) begin
            lock_d = Lockout | valid;
            if (!Foul) begin
              foul_d = 1'b1;
              fid_d  = first;
            end
          end
          if (Host_Go) begin
            state_d = S_OPEN;
            start_d = 1'b0;
            ts_d    = 1'b0;
          end
        end
        S_OPEN: begin
          if (any) begin
            state_d = S_ANSWER;
            ts_d    = 1'b1;
            ans_d   = 1'b1;
            wv_d    = 1'b1;
            wid_d   = first;
            led_d   = N_PLAYERS'(1) << first;
          end else if (TimeOver_Stop) begin
            state_d = S_EXPIRED;
            exp_d   = 1'b1;
          end
        end
        S_ANSWER: begin
          if (Host_Stop) begin
            state_d = S_DONE;
            ans_d   = 1'b0;
          end else if (TimeOver_Stop) begin
            state_d = S_EXPIRED;
            ans_d   = 1'b0;
            exp_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= S_IDLE;
      Start         <= 1'b1;
      Timer_Start   <= 1'b0;
      Answer        <= 1'b0;
      Winner_Valid  <= 1'b0;
      Winner_ID     <= '0;
      Player_LED    <= '0;
      Foul          <= 1'b0;
      Foul_ID       <= '0;
      Lockout       <= '0;
      Round_Expired <= 1'b0;
    end else begin
      state_q       <= state_d;
      Start         <= start_d;
      Timer_Start   <= ts_d;
      Answer        <= ans_d;
      Winner_Valid  <= wv_d;
      Winner_ID     <= wid_d;
      Player_LED    <= led_d;
      Foul          <= foul_d;
      Foul_ID       <= fid_d;
      Lockout       <= lock_d;
      Round_Expired <= exp_d;
    end
  end

endmodule

// File: tb/tb_responder_arbiter.sv
// Bench for responder_arbiter: rounds are scripted (directed, then random); expected events
// go into a scoreboard queue and a negedge monitor pops them as the DUT raises its outputs.
module tb_responder_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic       CLK = 0, RSTn = 0;
  logic [3:0] Key = '0;
  logic       Host_Go = 0, Host_Stop = 0, Host_Reset = 0, TimeOver_Stop = 0;
  logic       Start, Timer_Start, Answer, Winner_Valid, Foul, Round_Expired;
  logic [1:0] Winner_ID, Foul_ID;
  logic [3:0] Player_LED, Lockout;

  responder_arbiter #(.N_PLAYERS(N), .DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .RSTn(RSTn), .Key(Key), .Host_Go(Host_Go), .Host_Stop(Host_Stop),
    .Host_Reset(Host_Reset), .TimeOver_Stop(TimeOver_Stop), .Start(Start),
    .Timer_Start(Timer_Start), .Answer(Answer), .Winner_Valid(Winner_Valid),
    .Winner_ID(Winner_ID), .Player_LED(Player_LED), .Foul(Foul), .Foul_ID(Foul_ID),
    .Lockout(Lockout), .Round_Expired(Round_Expired)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef enum int {K_FOUL, K_WIN, K_EXP, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    id;
    int    cyc;
    logic  ts;
    logic  wv;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input kind_t k, input int id, input int c, input logic ts, input logic wv);
    exp_t e;
    e.kind = k; e.id = id; e.cyc = c; e.ts = ts; e.wv = wv;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got_v, exp_v);
    end
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Monitor: every rising output event must match the next scoreboard entry
  task automatic got(input kind_t k);
    exp_t e;
    logic ok;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d id %0d, required no event", k, cyc, Winner_ID);
      return;
    end
    e  = sb.pop_front();
    ok = (e.kind == k) && (e.cyc == cyc);
    case (k)
      K_FOUL: ok &= (Foul_ID == 2'(e.id));
      K_WIN:  ok &= (Winner_ID == 2'(e.id)) && (Player_LED == (4'b0001 << e.id)) && Answer && Timer_Start && !Start;
      K_EXP:  ok &= (Timer_Start == e.ts) && (Winner_Valid == e.wv) && !Answer && (!e.wv || Winner_ID == 2'(e.id));
      K_DONE: ok &= Timer_Start && !Round_Expired && (Winner_ID == 2'(e.id));
      default: ;
    endcase
    if (!ok) begin
      errors++;
      $display("FAIL event: got kind %0d cyc %0d wid %0d fid %0d led %b ts %0b ans %0b wv %0b, required kind %0d cyc %0d id %0d ts %0b wv %0b",
               k, cyc, Winner_ID, Foul_ID, Player_LED, Timer_Start, Answer, Winner_Valid, e.kind, e.cyc, e.id, e.ts, e.wv);
    end
  endtask

  logic p_foul = 0, p_wv = 0, p_exp = 0, p_ans = 0;
  always @(negedge CLK) begin
    if (RSTn) begin
      if (Foul && !p_foul) got(K_FOUL);
      if (Winner_Valid && !p_wv) got(K_WIN);
      if (Round_Expired && !p_exp) got(K_EXP);
      if (!Answer && p_ans && Winner_Valid && !Round_Expired) got(K_DONE);
    end
    p_foul = Foul; p_wv = Winner_Valid; p_exp = Round_Expired; p_ans = Answer;
  end

  // Hold mask high for 'hold' cycles; optional one-cycle Host_Go / TimeOver_Stop at given offsets
  task automatic drive_press(input logic [3:0] mask, input int hold, input int go_at, input int tmo_at);
    Key = Key | mask;
    for (int i = 1; i <= D + 8; i++) begin
      tick();
      if (i == hold) Key = Key & ~mask;
      Host_Go       = (i == go_at);
      TimeOver_Stop = (i == tmo_at);
    end
    Host_Go = 0;
    TimeOver_Stop = 0;
    repeat (D + 6) tick();
  endtask

  function automatic logic [17:0] all_out();
    return {Start, Timer_Start, Answer, Winner_Valid, Winner_ID, Player_LED, Foul, Foul_ID, Lockout, Round_Expired};
  endfunction

  task automatic round(input int nf, input int fk0, input int fk1, input bit go_race,
                       input logic [3:0] open_mask, input bit glitch, input bit tmo_race,
                       input bit ans_press, input int end_mode, input bit post_press);
    logic [3:0] lock = '0;
    logic [3:0] valid;
    logic foul = 0, wv = 0, expd = 0;
    int fid = 0, wid = 0, k;
    bit gr;
    for (int f = 0; f < nf; f++) begin
      k  = (f == 0) ? fk0 : fk1;
      gr = go_race && (f == nf - 1);
      if (!lock[k]) begin
        if (!foul) begin
          push(K_FOUL, k, cyc + D + 4, 0, 0);
          foul = 1;
          fid  = k;
        end
        lock[k] = 1'b1;
      end
      drive_press(4'(1 << k), D + 1, gr ? D + 3 : -1, -1);
    end
    if (!(go_race && nf > 0)) begin
      Host_Go = 1; tick(); Host_Go = 0; tick();
    end
    if (glitch) begin
      Key[2] = 1; repeat (D - 1) tick(); Key[2] = 0; repeat (D + 6) tick();
    end
    if (open_mask != 0) begin
      valid = open_mask & ~lock;
      if (valid != 0) begin
        wv = 1; wid = lowest(valid);
        push(K_WIN, wid, cyc + D + 4, 1, 1);
      end else if (tmo_race) begin
        expd = 1;
        push(K_EXP, 0, cyc + D + 4, 0, 0);
      end
      drive_press(open_mask, D + int'($urandom_range(0, 3)), -1, tmo_race ? D + 3 : -1);
    end
    if (!wv && !expd) begin
      expd = 1;
      push(K_EXP, 0, cyc + 1, 0, 0);
      TimeOver_Stop = 1; tick(); TimeOver_Stop = 0;
    end
    if (wv) begin
      if (ans_press) drive_press(4'(1 << $urandom_range(0, 3)), D + 1, -1, -1);
      Host_Stop     = (end_mode != 1);
      TimeOver_Stop = (end_mode != 0);
      if (end_mode == 1) begin
        expd = 1;
        push(K_EXP, wid, cyc + 1, 1, 1);
      end else begin
        push(K_DONE, wid, cyc + 1, 1, 1);
      end
      tick(); Host_Stop = 0; TimeOver_Stop = 0;
    end
    repeat (3) tick();
    if (post_press) drive_press(4'(1 << $urandom_range(0, 3)), D + 1, -1, -1);
    check("round_end", 32'({Lockout, Foul, Foul_ID, Winner_Valid, Winner_ID, Round_Expired, Answer, Start}),
          32'({lock, foul, 2'(fid), wv, wv ? 2'(wid) : 2'd0, expd, 1'b0, 1'b0}));
    check("events_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    Host_Reset = 1; tick(); Host_Reset = 0;
    check("host_reset", 32'(all_out()), 32'h0002_0000);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("in_reset", 32'(all_out()), 32'h0002_0000);
    RSTn = 1;
    tick();
    check("after_reset", 32'(all_out()), 32'h0002_0000);
    tick();

    round(0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0);   // single press, key 2 wins
    round(0, 0, 0, 0, 4'b1010, 0, 0, 0, 0, 0);   // simultaneous 1 and 3
    round(1, 0, 0, 0, 4'b1001, 0, 0, 0, 0, 0);   // foul by 0, then 3 wins
    round(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0);   // glitch only, then timeout
    round(0, 0, 0, 0, 4'b0001, 0, 0, 0, 2, 1);   // stop and timeout together
    round(1, 1, 0, 1, 4'b0010, 0, 0, 0, 0, 0);   // foul with Host_Go, locked key ignored
    round(0, 0, 0, 0, 4'b0100, 0, 1, 1, 1, 1);   // press beats timeout, then answer timeout

    for (int r = 0; r < 40; r++) begin
      round(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
            ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    Host_Go = 1; tick(); Host_Go = 0; tick();
    push(K_WIN, 0, cyc + D + 4, 1, 1);
    drive_press(4'b0001, D + 1, -1, -1);
    #3 RSTn = 0;
    #1 check("async_reset", 32'({Winner_Valid, Start, Answer}), 32'b010);
    tick();
    RSTn = 1;
    tick();
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
